axi_prewrapper_mc: RTL and testbench
====================================

# axi_prewrapper_mc

Multi-channel successor to the single-chain AXI pre-wrapper. It is a register-mapped bridge between the AXI-side address/message bus and one design under test (DUT) with up to 16 design-for-test (DFT) scan channels. It sequences the DUT and DFT operation/commit handshakes with a state machine and a timeout. Each channel's strobed scan output is buffered in its own FIFO so that software can drain it through a channel-select window.

## Interface
- `p_chan_nbr`, 4: number of DFT channels, 1..16.
- `p_fifo_depth`, 8: entries per channel FIFO; power of two, ≥2.
- `dut_input_width`, 32: DUT input vector width, 1..32.
- `dut_output_width`, 32: DUT output vector width, 1..32.
- `p_timeout`, 1024: maximum cycles spent waiting in any handshake state.
- `clk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `axi_rd_en` in 1: read strobe.
- `axi_rd_addr` in 32: read byte address; bits [4:2] decode the register.
- `axi_rd_msg` out 32: registered read data.
- `axi_wr_en` in 1: write strobe.
- `axi_wr_addr` in 32: write byte address.
- `axi_wr_msg` in 32: write data.
- `dut_input_vec` out `dut_input_width`: DIN register.
- `dut_output_vec` in `dut_output_width`: DUT result.
- `dut_val_op` out 1: DUT operation request.
- `dut_op_ack` in 1: DUT accepts the request.
- `dut_op_commit` in 1: DUT result is valid.
- `dut_commit_ack` out 1: one-cycle commit acknowledge.
- `dut_sen` out 1: scan enable, taken from CTRL bit 2.
- `dft_val_op` out 1: DFT request, broadcast to all channels.
- `dft_op_ack` in `p_chan_nbr`: per-channel accept.
- `dft_op_commit` in `p_chan_nbr`: per-channel done.
- `dft_output_strobe` in `p_chan_nbr`: per-channel push of scan data.
- `dft_output_data` in 32·`p_chan_nbr`: channel c occupies bits [32c+31:32c].
- `dft_commit_ack` out 1: one-cycle acknowledge, broadcast to all channels.

## Operation
- Register map:
  - 0x00 CTRL (write): bit0 start DUT op; bit1 start DFT op; bit2 sen (level); bit3 clear FIFOs and sticky flags.
  - 0x04 STATUS (read): bit0 busy; [3:1] state; bit4 done; bit5 timeout error; bit6 any-channel overflow.
  - 0x08 DIN (read/write).
  - 0x0C DOUT (read): DUT output captured at commit, zero-extended.
  - 0x10 CHSEL (read/write): bits [3:0]; values ≥ `p_chan_nbr` read as empty.
  - 0x14 POP (read): returns the head of the selected FIFO and pops it. An empty FIFO returns 0 and does not pop.
  - 0x18 LEVEL (read): [4:0] occupancy of the selected FIFO; bit31 that channel's sticky overflow.
  - Unmapped addresses read 0 and ignore writes.
- Writes to CTRL while busy are ignored, including the clear bit. CTRL sen bit, DIN and CHSEL are writable at any time.
- States:
  - IDLE(0): on a CTRL write, go to DUT_REQ if bit0 is set, otherwise to DFT_REQ if bit1 is set. Clear done and error on entry to either. If both bits are set, DUT runs first and DFT follows automatically.
  - DUT_REQ(1): `dut_val_op`=1 until `dut_op_ack`, then go to DUT_WAIT.
  - DUT_WAIT(2): on `dut_op_commit`, capture DOUT and go to DUT_ACK.
  - DUT_ACK(3): `dut_commit_ack`=1 for one cycle. Next state is DFT_REQ if a DFT op is pending, otherwise IDLE with done=1.
  - DFT_REQ(4): `dft_val_op`=1. A sticky per-channel ack mask collects `dft_op_ack`. When all channels have acked, go to DFT_WAIT.
  - DFT_WAIT(5): a sticky commit mask collects `dft_op_commit`. When all channels have committed, go to DFT_ACK.
  - DFT_ACK(6): `dft_commit_ack`=1 for one cycle, then IDLE with done=1.
- Timeout: an occupancy counter resets on entry to each of states 1, 2, 4, 5. At `p_timeout` cycles the block goes to IDLE with error=1, clears any pending op and the sticky masks, and asserts no ack pulse.
- FIFOs:
  - `dft_output_strobe[c]` pushes that channel's data in any state.
  - A push to a full FIFO drops the data and sets overflow[c].
  - Push and pop on the same cycle when full: pop then push, occupancy unchanged, no overflow.
  - Push and pop on the same cycle when empty: the push succeeds and the read returns 0.
  - Read/write pointers wrap modulo `p_fifo_depth`.

## Timing
- Reset values:
  - All outputs are 0, including `axi_rd_msg`, `dut_input_vec`, `dut_sen` and every handshake output.
  - State is IDLE; FIFOs are empty; all sticky flags, DOUT and CHSEL are 0.
- A reset asserted mid-operation aborts it on that edge; no ack pulse is emitted afterwards.
- Read latency: `axi_rd_msg` is valid on the cycle after `axi_rd_en` and holds until the next read. The POP side effect occurs on the `axi_rd_en` edge.
- A CTRL write at edge t asserts `dut_val_op` (or `dft_val_op`) after t.
- Request deassertion: an ack sampled at edge t deasserts the request after t.
- Commit timing: a commit sampled at edge t gives ack high for exactly the cycle after t.
- DUT→DFT chaining adds no idle cycle: `dft_val_op` rises the cycle after `dut_commit_ack`.
- Done and error are set on the edge that enters IDLE.
- LEVEL reflects pushes and pops up to the previous edge.

## Test plan
- DUT only: write DIN=0xA5A5_0001 and CTRL=0x1; ack at +3, commit with output 0x1234 at +6 → `dut_commit_ack` high for one cycle at +7; DOUT=0x0000_1234; STATUS done=1, busy=0.
- DUT then DFT (4 channels): write CTRL=0x3; channels ack at different cycles (1, 3, 2, 5) → `dft_val_op` drops only after the last ack; one `dft_commit_ack` pulse after the last commit.
- FIFO fill: channel 2 strobes 9 words 0x100..0x108 with depth 8 → LEVEL=8, bit31=1; eight POP reads return 0x100..0x107; a ninth POP returns 0 and LEVEL=0.
- Full plus simultaneous: full FIFO with push and pop on the same cycle → occupancy stays 8, no overflow, data order preserved.
- Timeout: write CTRL=0x1 and never ack → after 1024 cycles state=IDLE, error=1, `dut_val_op`=0; a following CTRL write clears error.
- Reset during DFT_WAIT: all outputs return to 0 next cycle; no `dft_commit_ack` pulse; FIFOs read empty.

Source files
------------

// File: rtl/axi_prewrapper_mc_if.sv
// Signal bundle linking axi_prewrapper_mc to the AXI-side bus, the DUT and its DFT scan channels.
interface axi_prewrapper_mc_if #(
   parameter int p_chan_nbr       = 4,
   parameter int dut_input_width  = 32,
   parameter int dut_output_width = 32
);
   logic                          axi_rd_en;
   logic [31:0]                   axi_rd_addr;
   logic [31:0]                   axi_rd_msg;
   logic                          axi_wr_en;
   logic [31:0]                   axi_wr_addr;
   logic [31:0]                   axi_wr_msg;

   logic [dut_input_width-1:0]    dut_input_vec;
   logic [dut_output_width-1:0]   dut_output_vec;
   logic                          dut_val_op;
   logic                          dut_op_ack;
   logic                          dut_op_commit;
   logic                          dut_commit_ack;
   logic                          dut_sen;

   logic                          dft_val_op;
   logic [p_chan_nbr-1:0]         dft_op_ack;
   logic [p_chan_nbr-1:0]         dft_op_commit;
   logic [p_chan_nbr-1:0]         dft_output_strobe;
   logic [32*p_chan_nbr-1:0]      dft_output_data;
   logic                          dft_commit_ack;

   modport slave (
      input  axi_rd_en, axi_rd_addr, axi_wr_en, axi_wr_addr, axi_wr_msg,
      input  dut_output_vec, dut_op_ack, dut_op_commit,
      input  dft_op_ack, dft_op_commit, dft_output_strobe, dft_output_data,
      output axi_rd_msg, dut_input_vec, dut_val_op, dut_commit_ack, dut_sen,
      output dft_val_op, dft_commit_ack
   );

   modport master (
      output axi_rd_en, axi_rd_addr, axi_wr_en, axi_wr_addr, axi_wr_msg,
      output dut_output_vec, dut_op_ack, dut_op_commit,
      output dft_op_ack, dft_op_commit, dft_output_strobe, dft_output_data,
      input  axi_rd_msg, dut_input_vec, dut_val_op, dut_commit_ack, dut_sen,
      input  dft_val_op, dft_commit_ack
   );
endinterface

// File: rtl/axi_prewrapper_mc.sv
// Register-mapped bridge sequencing DUT and multi-channel DFT handshakes, with one scan-output
// FIFO per channel drained through a channel-select window.
module axi_prewrapper_mc #(
   parameter int p_chan_nbr       = 4,
   parameter int p_fifo_depth     = 8,
   parameter int dut_input_width  = 32,
   parameter int dut_output_width = 32,
   parameter int p_timeout        = 1024
) (
   input logic                clk,
   input logic                reset,
   axi_prewrapper_mc_if.slave bus
);
   localparam int AW = $clog2(p_fifo_depth);
   localparam int TW = $clog2(p_timeout + 1);
   localparam logic [AW:0]           FULL_OCC = (AW+1)'(p_fifo_depth);
   localparam logic [TW-1:0]         TMO_LAST = TW'(p_timeout - 1);
   localparam logic [p_chan_nbr-1:0] ALL_CH   = {p_chan_nbr{1'b1}};

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_DIN    = 3'd2;
   localparam logic [2:0] A_DOUT   = 3'd3;
   localparam logic [2:0] A_CHSEL  = 3'd4;
   localparam logic [2:0] A_POP    = 3'd5;
   localparam logic [2:0] A_LEVEL  = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DUT_REQ  = 3'd1,
      S_DUT_WAIT = 3'd2,
      S_DUT_ACK  = 3'd3,
      S_DFT_REQ  = 3'd4,
      S_DFT_WAIT = 3'd5,
      S_DFT_ACK  = 3'd6
   } state_t;

   state_t                state, state_nxt;
   logic [TW-1:0]         tcnt;
   logic                  tmo;
   logic                  fin_ok, fin_err;
   logic                  dft_pend, done, err, busy;
   logic [p_chan_nbr-1:0] ack_mask, cmt_mask, ovf;
   logic [31:0]           din, dout, rd_msg;
   logic [3:0]            chsel;
   logic                  sen;

   logic [2:0]            rd_idx, wr_idx;
   logic                  ctrl_wr, ctrl_ok, fifo_clr, pop_rd;
   logic                  unused_addr;

   logic [31:0]           mem [p_chan_nbr][p_fifo_depth];
   logic [AW:0]           wptr [p_chan_nbr];
   logic [AW:0]           rptr [p_chan_nbr];
   logic [AW:0]           occ  [p_chan_nbr];
   logic [p_chan_nbr-1:0] pop, push_ok;
   logic [AW:0]           sel_occ;
   logic [31:0]           sel_head, lvl;
   logic                  sel_ovf;

   assign rd_idx      = bus.axi_rd_addr[4:2];
   assign wr_idx      = bus.axi_wr_addr[4:2];
   assign unused_addr = &{1'b0, bus.axi_rd_addr[31:5], bus.axi_rd_addr[1:0],
                          bus.axi_wr_addr[31:5], bus.axi_wr_addr[1:0]};

   assign busy     = (state != S_IDLE);
   assign ctrl_wr  = bus.axi_wr_en && (wr_idx == A_CTRL);
   assign ctrl_ok  = ctrl_wr && !busy;
   assign fifo_clr = ctrl_ok && bus.axi_wr_msg[3];
   assign pop_rd   = bus.axi_rd_en && (rd_idx == A_POP);
   assign tmo      = (tcnt == TMO_LAST);

   assign bus.axi_rd_msg    = rd_msg;
   assign bus.dut_input_vec = din[dut_input_width-1:0];
   assign bus.dut_sen       = sen;

   // Next state and handshake outputs; progress always wins over a same-cycle timeout.
   always_comb begin
      state_nxt          = state;
      fin_ok             = 1'b0;
      fin_err            = 1'b0;
      bus.dut_val_op     = 1'b0;
      bus.dut_commit_ack = 1'b0;
      bus.dft_val_op     = 1'b0;
      bus.dft_commit_ack = 1'b0;
      case (state)
         S_IDLE: begin
            if (ctrl_ok) begin
               if (bus.axi_wr_msg[0])      state_nxt = S_DUT_REQ;
               else if (bus.axi_wr_msg[1]) state_nxt = S_DFT_REQ;
            end
         end
         S_DUT_REQ: begin
            bus.dut_val_op = 1'b1;
            if (bus.dut_op_ack) state_nxt = S_DUT_WAIT;
            else if (tmo) begin
               state_nxt = S_IDLE;
               fin_err   = 1'b1;
            end
         end
         S_DUT_WAIT: begin
            if (bus.dut_op_commit) state_nxt = S_DUT_ACK;
            else if (tmo) begin
               state_nxt = S_IDLE;
               fin_err   = 1'b1;
            end
         end
         S_DUT_ACK: begin
            bus.dut_commit_ack = 1'b1;
            if (dft_pend) state_nxt = S_DFT_REQ;
            else begin
               state_nxt = S_IDLE;
               fin_ok    = 1'b1;
            end
         end
         S_DFT_REQ: begin
            bus.dft_val_op = 1'b1;
            if ((ack_mask | bus.dft_op_ack) == ALL_CH) state_nxt = S_DFT_WAIT;
            else if (tmo) begin
               state_nxt = S_IDLE;
               fin_err   = 1'b1;
            end
         end
         S_DFT_WAIT: begin
            if ((cmt_mask | bus.dft_op_commit) == ALL_CH) state_nxt = S_DFT_ACK;
            else if (tmo) begin
               state_nxt = S_IDLE;
               fin_err   = 1'b1;
            end
         end
         S_DFT_ACK: begin
            bus.dft_commit_ack = 1'b1;
            state_nxt          = S_IDLE;
            fin_ok             = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         tcnt     <= '0;
         dft_pend <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         ack_mask <= '0;
         cmt_mask <= '0;
         sen      <= 1'b0;
         din      <= '0;
         dout     <= '0;
         chsel    <= '0;
      end else begin
         state    <= state_nxt;
         tcnt     <= (state_nxt == state && busy) ? tcnt + 1'b1 : '0;
         ack_mask <= (state == S_DFT_REQ && state_nxt == S_DFT_REQ) ? (ack_mask | bus.dft_op_ack) : '0;
         cmt_mask <= (state == S_DFT_WAIT && state_nxt == S_DFT_WAIT) ? (cmt_mask | bus.dft_op_commit) : '0;
         if (!busy && state_nxt != S_IDLE) begin
            done     <= 1'b0;
            err      <= 1'b0;
            dft_pend <= bus.axi_wr_msg[0] & bus.axi_wr_msg[1];
         end
         if (state == S_DUT_ACK && state_nxt == S_DFT_REQ) dft_pend <= 1'b0;
         if (fin_ok) done <= 1'b1;
         if (fin_err) begin
            err      <= 1'b1;
            dft_pend <= 1'b0;
         end
         if (fifo_clr) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (ctrl_wr) sen <= bus.axi_wr_msg[2];
         if (bus.axi_wr_en && wr_idx == A_DIN) din <= bus.axi_wr_msg;
         if (bus.axi_wr_en && wr_idx == A_CHSEL) chsel <= bus.axi_wr_msg[3:0];
         if (state == S_DUT_WAIT && bus.dut_op_commit) dout <= 32'(bus.dut_output_vec);
      end
   end

   // A pop frees a slot first, so a push to a full FIFO in the same cycle is accepted.
   always_comb begin
      for (int c = 0; c < p_chan_nbr; c++) begin
         occ[c]     = wptr[c] - rptr[c];
         pop[c]     = pop_rd && (chsel == 4'(c)) && (occ[c] != '0);
         push_ok[c] = bus.dft_output_strobe[c] && ((occ[c] != FULL_OCC) || pop[c]);
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < p_chan_nbr; c++) begin
         if (push_ok[c]) mem[c][wptr[c][AW-1:0]] <= bus.dft_output_data[32*c +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || fifo_clr) begin
         for (int c = 0; c < p_chan_nbr; c++) begin
            wptr[c] <= '0;
            rptr[c] <= '0;
         end
         ovf <= '0;
      end else begin
         for (int c = 0; c < p_chan_nbr; c++) begin
            if (push_ok[c]) wptr[c] <= wptr[c] + 1'b1;
            if (pop[c])     rptr[c] <= rptr[c] + 1'b1;
            if (bus.dft_output_strobe[c] && !push_ok[c]) ovf[c] <= 1'b1;
         end
      end
   end

   // Channel-select window; out-of-range selections fall through as an empty channel.
   always_comb begin
      sel_occ  = '0;
      sel_head = '0;
      sel_ovf  = 1'b0;
      for (int c = 0; c < p_chan_nbr; c++) begin
         if (chsel == 4'(c)) begin
            sel_occ  = occ[c];
            sel_head = (occ[c] != '0) ? mem[c][rptr[c][AW-1:0]] : '0;
            sel_ovf  = ovf[c];
         end
      end
      lvl         = '0;
      lvl[AW:0]   = sel_occ;
      lvl[31]     = sel_ovf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_msg <= '0;
      end else if (bus.axi_rd_en) begin
         case (rd_idx)
            A_STATUS: rd_msg <= {25'd0, |ovf, err, done, state, busy};
            A_DIN:    rd_msg <= din;
            A_DOUT:   rd_msg <= dout;
            A_CHSEL:  rd_msg <= {28'd0, chsel};
            A_POP:    rd_msg <= sel_head;
            A_LEVEL:  rd_msg <= lvl;
            default:  rd_msg <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_prewrapper_mc.sv
// Directed bench for axi_prewrapper_mc: DUT/DFT sequencing, FIFO window, timeout and reset abort.
module tb_axi_prewrapper_mc;
   localparam int NCH = 4;
   localparam logic [31:0] R_CTRL   = 32'h00;
   localparam logic [31:0] R_STATUS = 32'h04;
   localparam logic [31:0] R_DIN    = 32'h08;
   localparam logic [31:0] R_DOUT   = 32'h0C;
   localparam logic [31:0] R_CHSEL  = 32'h10;
   localparam logic [31:0] R_POP    = 32'h14;
   localparam logic [31:0] R_LEVEL  = 32'h18;
   localparam logic [31:0] R_UNMAP  = 32'h1C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] v;
   int          n_total = 0;
   int          n_bad   = 0;

   always #5 clk = ~clk;

   axi_prewrapper_mc_if #(.p_chan_nbr(NCH), .dut_input_width(32), .dut_output_width(32)) bus ();

   axi_prewrapper_mc #(
      .p_chan_nbr(NCH), .p_fifo_depth(8), .dut_input_width(32),
      .dut_output_width(32), .p_timeout(1024)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.axi_wr_en = 1'b1; bus.axi_wr_addr = a; bus.axi_wr_msg = d;
      step(1);
      bus.axi_wr_en = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.axi_rd_en = 1'b1; bus.axi_rd_addr = a;
      step(1);
      bus.axi_rd_en = 1'b0;
      d = bus.axi_rd_msg;
   endtask

   task automatic push(input int ch, input logic [31:0] d);
      bus.dft_output_strobe = NCH'(1 << ch);
      bus.dft_output_data[32*ch +: 32] = d;
      step(1);
      bus.dft_output_strobe = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.axi_rd_en = 1'b0; bus.axi_rd_addr = '0;
      bus.axi_wr_en = 1'b0; bus.axi_wr_addr = '0; bus.axi_wr_msg = '0;
      bus.dut_output_vec = '0; bus.dut_op_ack = 1'b0; bus.dut_op_commit = 1'b0;
      bus.dft_op_ack = '0; bus.dft_op_commit = '0;
      bus.dft_output_strobe = '0; bus.dft_output_data = '0;
      step(3);
      reset = 1'b0;

      // reset state
      check("rst_outs", {26'd0, bus.dut_val_op, bus.dut_commit_ack, bus.dut_sen,
                         bus.dft_val_op, bus.dft_commit_ack, 1'b0}, 32'd0);
      check("rst_rd_msg", bus.axi_rd_msg, 32'd0);
      check("rst_din", bus.dut_input_vec, 32'd0);
      rd(R_STATUS, v); check("rst_status", v, 32'd0);
      rd(R_LEVEL, v);  check("rst_level", v, 32'd0);

      // DUT-only operation
      wr(R_DIN, 32'hA5A5_0001);
      check("t1_din_out", bus.dut_input_vec, 32'hA5A5_0001);
      wr(R_CTRL, 32'h1);
      check("t1_val_up", bus.dut_val_op, 1);
      step(1);
      check("t1_val_hold", bus.dut_val_op, 1);
      bus.dut_op_ack = 1'b1; step(1); bus.dut_op_ack = 1'b0;
      check("t1_val_down", bus.dut_val_op, 0);
      step(2);
      bus.dut_output_vec = 32'h1234; bus.dut_op_commit = 1'b1; step(1); bus.dut_op_commit = 1'b0;
      check("t1_cack_hi", bus.dut_commit_ack, 1);
      step(1);
      check("t1_cack_lo", bus.dut_commit_ack, 0);
      rd(R_DOUT, v);   check("t1_dout", v, 32'h0000_1234);
      rd(R_STATUS, v); check("t1_status", v, 32'h10);
      rd(R_DIN, v);    check("t1_din_rd", v, 32'hA5A5_0001);

      // DUT then DFT, staggered channel acks and commits
      wr(R_CTRL, 32'h3);
      check("t2_val_up", bus.dut_val_op, 1);
      bus.dut_op_ack = 1'b1; step(1); bus.dut_op_ack = 1'b0;
      bus.dut_op_commit = 1'b1; step(1); bus.dut_op_commit = 1'b0;
      check("t2_cack", bus.dut_commit_ack, 1);
      check("t2_dft_not_yet", bus.dft_val_op, 0);
      step(1);
      check("t2_dft_up", bus.dft_val_op, 1);
      check("t2_cack_lo", bus.dut_commit_ack, 0);
      for (int k = 1; k <= 5; k++) begin
         bus.dft_op_ack = {k == 5, k == 2, k == 3, k == 1};
         step(1);
         bus.dft_op_ack = '0;
         check($sformatf("t2_dft_val_k%0d", k), bus.dft_val_op, (k < 5) ? 1 : 0);
      end
      for (int k = 1; k <= 4; k++) begin
         bus.dft_op_commit = {k == 1, k == 3, k == 4, k == 2};
         step(1);
         bus.dft_op_commit = '0;
         check($sformatf("t2_dft_cack_k%0d", k), bus.dft_commit_ack, (k == 4) ? 1 : 0);
      end
      step(1);
      check("t2_dft_cack_lo", bus.dft_commit_ack, 0);
      rd(R_STATUS, v); check("t2_status", v, 32'h10);

      // FIFO overfill on channel 2
      wr(R_CHSEL, 32'h2);
      for (int i = 0; i < 9; i++) push(2, 32'h100 + i);
      rd(R_LEVEL, v);  check("t3_level_full", v, 32'h8000_0008);
      rd(R_STATUS, v); check("t3_status_ovf", v, 32'h50);
      for (int i = 0; i < 8; i++) begin
         rd(R_POP, v); check($sformatf("t3_pop%0d", i), v, 32'h100 + i);
      end
      rd(R_POP, v);   check("t3_pop_empty", v, 32'h0);
      rd(R_LEVEL, v); check("t3_level_empty", v, 32'h8000_0000);
      wr(R_CTRL, 32'h8);
      rd(R_LEVEL, v);  check("t3_level_clr", v, 32'h0);
      rd(R_STATUS, v); check("t3_ovf_clr", v & 32'h40, 32'h0);

      // full FIFO with simultaneous push and pop, then empty with both
      for (int i = 0; i < 8; i++) push(2, 32'h200 + i);
      rd(R_LEVEL, v); check("t4_level8", v, 32'h8);
      bus.dft_output_strobe = 4'b0100; bus.dft_output_data[95:64] = 32'h208;
      bus.axi_rd_en = 1'b1; bus.axi_rd_addr = R_POP;
      step(1);
      bus.dft_output_strobe = '0; bus.axi_rd_en = 1'b0;
      check("t4_pp_full_rd", bus.axi_rd_msg, 32'h200);
      rd(R_LEVEL, v); check("t4_level_still8", v, 32'h8);
      for (int i = 1; i <= 8; i++) begin
         rd(R_POP, v); check($sformatf("t4_pop%0d", i), v, 32'h200 + i);
      end
      bus.dft_output_strobe = 4'b0100; bus.dft_output_data[95:64] = 32'h300;
      bus.axi_rd_en = 1'b1; bus.axi_rd_addr = R_POP;
      step(1);
      bus.dft_output_strobe = '0; bus.axi_rd_en = 1'b0;
      check("t4_pp_empty_rd", bus.axi_rd_msg, 32'h0);
      rd(R_LEVEL, v); check("t4_level1", v, 32'h1);
      rd(R_POP, v);   check("t4_pop300", v, 32'h300);
      wr(R_CHSEL, 32'h5);
      rd(R_CHSEL, v); check("t4_chsel_rd", v, 32'h5);
      rd(R_LEVEL, v); check("t4_oor_level", v, 32'h0);
      rd(R_POP, v);   check("t4_oor_pop", v, 32'h0);
      rd(R_UNMAP, v); check("t4_unmapped", v, 32'h0);

      // timeout in DUT_REQ
      wr(R_CTRL, 32'h1);
      step(1023);
      check("t5_val_before_tmo", bus.dut_val_op, 1);
      step(1);
      check("t5_val_after_tmo", bus.dut_val_op, 0);
      check("t5_no_cack", bus.dut_commit_ack, 0);
      rd(R_STATUS, v); check("t5_status_err", v, 32'h20);
      wr(R_CTRL, 32'h1);
      rd(R_STATUS, v); check("t5_err_cleared", v, 32'h3);
      bus.dut_op_ack = 1'b1; step(1); bus.dut_op_ack = 1'b0;
      bus.dut_op_commit = 1'b1; step(1); bus.dut_op_commit = 1'b0;
      check("t5_cack", bus.dut_commit_ack, 1);
      step(1);
      rd(R_STATUS, v); check("t5_status_done", v, 32'h10);

      // reset while in DFT_WAIT
      wr(R_CHSEL, 32'h1);
      push(1, 32'hDEAD);
      wr(R_CTRL, 32'h6);
      check("t6_sen", bus.dut_sen, 1);
      check("t6_dft_up", bus.dft_val_op, 1);
      bus.dft_op_ack = 4'hF; step(1); bus.dft_op_ack = '0;
      check("t6_in_wait", bus.dft_val_op, 0);
      reset = 1'b1; bus.dft_op_commit = 4'hF;
      step(1);
      reset = 1'b0; bus.dft_op_commit = '0;
      check("t6_outs", {26'd0, bus.dut_val_op, bus.dut_commit_ack, bus.dut_sen,
                        bus.dft_val_op, bus.dft_commit_ack, 1'b0}, 32'd0);
      check("t6_din", bus.dut_input_vec, 32'd0);
      check("t6_rd_msg", bus.axi_rd_msg, 32'd0);
      step(1);
      check("t6_no_cack", bus.dft_commit_ack, 0);
      rd(R_STATUS, v); check("t6_status", v, 32'h0);
      rd(R_CHSEL, v);  check("t6_chsel", v, 32'h0);
      wr(R_CHSEL, 32'h1);
      rd(R_LEVEL, v);  check("t6_level", v, 32'h0);
      rd(R_POP, v);    check("t6_pop", v, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
